uart_rx_fifo_gen2: RTL and testbench

Second-generation UART receiver with a run-time data length of 5..MAX_WIDTH bits, optional parity, 1 or 2 stop bits, and 3-sample majority voting. Completed frames and their per-frame error flags go into an internal FIFO. The FIFO drains through a valid/ready handshake. Sits between the RX pad synchroniser-free input and the register/DMA layer; it replaces single-frame receivers that have no buffering.

---
 rtl/uart_rx_fifo_gen2.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo_gen2.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_gen2.sv
// UART receiver with run-time frame format, 3-sample majority voting and a
// frame FIFO drained through a valid/ready handshake.
module uart_rx_fifo_gen2 #(
    parameter int unsigned MAX_WIDTH      = 9,
    parameter int unsigned PRESCALE_WIDTH = 6,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [3:0]                Data_Len,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    output logic [MAX_WIDTH-1:0]      P_DATA,
    output logic                      Par_Err,
    output logic                      Stp_Err,
    output logic                      Brk_Det,
    output logic                      Data_Valid,
    input  logic                      Data_Ready,
    output logic                      Overrun,
    output logic                      Busy
);
    localparam int unsigned PW = PRESCALE_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = MAX_WIDTH + 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

    state_t               state;
    logic                 rx_meta, rx_s, rx_prev;
    logic [PW-1:0]        edge_cnt, half;
    logic [3:0]           bit_cnt, len_l;
    logic                 par_en_l, par_typ_l, stop2_l, stop_idx;
    logic                 s0, s1, maj;
    logic                 at_s0, at_s1, at_mid, at_wrap;
    logic [MAX_WIDTH-1:0] data;
    logic                 par_bit, par_err, stp_err, brk;

    // Two-flop synchroniser plus one-cycle delay for start-edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign half    = Prescale >> 1;
    assign at_s0   = (edge_cnt == half - PW'(1));
    assign at_s1   = (edge_cnt == half);
    assign at_mid  = (edge_cnt == half + PW'(1));
    assign at_wrap = (edge_cnt == Prescale - PW'(1));
    assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            len_l     <= '0;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            stop2_l   <= 1'b0;
            stop_idx  <= 1'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            data      <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            brk       <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            edge_cnt <= at_wrap ? '0 : edge_cnt + PW'(1);
            if (at_s0) s0 <= rx_s;
            if (at_s1) s1 <= rx_s;
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state     <= START;
                        Busy      <= 1'b1;
                        len_l     <= Data_Len;
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        stop2_l   <= STOP2;
                        stop_idx  <= 1'b0;
                        bit_cnt   <= '0;
                        data      <= '0;
                        par_bit   <= 1'b0;
                        par_err   <= 1'b0;
                        stp_err   <= 1'b0;
                        brk       <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that reads high at mid-bit is line noise
                    if (at_mid && maj) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (at_wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_mid) begin
                        data    <= data | (MAX_WIDTH'(maj) << bit_cnt);
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if (at_wrap && bit_cnt == len_l)
                        state <= par_en_l ? PARITY : STOP;
                end
                PARITY: begin
                    if (at_mid) begin
                        par_bit <= maj;
                        par_err <= ((^data) ^ maj) != par_typ_l;
                    end
                    if (at_wrap) state <= STOP;
                end
                STOP: begin
                    if (at_mid) begin
                        if (!maj) stp_err <= 1'b1;
                        if (!stop_idx && !maj)
                            brk <= (data == '0) && !(par_en_l && par_bit);
                        if (!stop2_l || stop_idx) state <= PUSH;
                    end
                    if (at_wrap) stop_idx <= 1'b1;
                end
                PUSH: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_next, rd_next;
    logic [EW-1:0] push_word, head_next;
    logic          empty, full, pop, push_req, do_push;

    assign push_word = {brk, stp_err, par_err, data};
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && Data_Ready;
    assign push_req  = (state == PUSH);
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push
    assign do_push   = push_req && (!full || pop);
    assign rd_next   = rd_ptr + (AW+1)'(pop);
    assign wr_next   = wr_ptr + (AW+1)'(do_push);

    // Head register bypasses the array when the pushed frame becomes the head
    always_comb begin
        head_next = mem[rd_next[AW-1:0]];
        if (rd_next == wr_next)
            head_next = '0;
        else if (do_push && rd_next == wr_ptr)
            head_next = push_word;
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            P_DATA     <= '0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            Brk_Det    <= 1'b0;
            Data_Valid <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            {Brk_Det, Stp_Err, Par_Err, P_DATA} <= head_next;
            Data_Valid <= (rd_next != wr_next);
            Overrun    <= push_req && !do_push;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Directed bench for uart_rx_fifo_gen2: serial frames are driven bit by bit,
// expected FIFO entries are queued as frames are sent and compared on drain.
module tb_uart_rx_fifo_gen2;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic [3:0] Data_Len;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic [8:0] P_DATA;
    logic       Par_Err, Stp_Err, Brk_Det, Data_Valid, Data_Ready, Overrun, Busy;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    // Monitor state: Data_Valid rise alignment and Overrun pulse count
    logic dv_prev = 1'b0, busy_prev = 1'b0;
    logic rise_busy_prev = 1'b0, rise_busy_now = 1'b0;
    int   ovr_count = 0;

    uart_rx_fifo_gen2 #(.MAX_WIDTH(9), .PRESCALE_WIDTH(6), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .Data_Len(Data_Len), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .P_DATA(P_DATA), .Par_Err(Par_Err), .Stp_Err(Stp_Err), .Brk_Det(Brk_Det),
        .Data_Valid(Data_Valid), .Data_Ready(Data_Ready), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Data_Valid && !dv_prev) begin
            rise_busy_prev = busy_prev;
            rise_busy_now  = Busy;
        end
        if (Overrun) ovr_count++;
        dv_prev   = Data_Valid;
        busy_prev = Busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (int'(Prescale)) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input bit with_par,
                              input logic par_bit, input logic stop1, input bit two_stop,
                              input logic stop2v);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop1);
        if (two_stop) drive_bit(stop2v);
        RX_IN = 1'b1;
    endtask

    // Pops n entries with Data_Ready held high, comparing each against the queue
    task automatic drain(input int n);
        logic [11:0] exp;
        Data_Ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!Data_Valid && t < 200) begin
                @(negedge CLK);
                t++;
            end
            if (!Data_Valid) begin
                check("drain_valid", 32'(Data_Valid), 32'd1);
            end else begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
                check("head", 32'({Brk_Det, Stp_Err, Par_Err, P_DATA}), 32'(exp));
                @(negedge CLK);
            end
        end
        Data_Ready = 1'b0;
    endtask

    initial begin
        int base, t;
        RST = 1'b1; RX_IN = 1'b1; Data_Ready = 1'b0;
        Prescale = 6'd8; Data_Len = 4'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        idle(3);
        check("rst_valid", 32'(Data_Valid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_data", 32'(P_DATA), 32'd0);
        check("rst_flags", 32'({Brk_Det, Stp_Err, Par_Err, Overrun}), 32'd0);
        RST = 1'b0;
        idle(5);
        check("idle_busy", 32'(Busy), 32'd0);

        // 8N1 frame, Data_Valid must rise the cycle PUSH ends
        exp_q.push_back({3'b000, 9'h0A5});
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        idle(4);
        check("dv_latency", 32'({rise_busy_prev, rise_busy_now}), 32'b10);
        check("dv_hold", 32'(Data_Valid), 32'd1);
        drain(1);
        check("empty_after_1", 32'(Data_Valid), 32'd0);

        // 7E1 with wrong parity bit
        Data_Len = 4'd7; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        exp_q.push_back({3'b001, 9'h035});
        send_frame(9'h035, 7, 1, 1'b1, 1'b1, 0, 1'b1);
        idle(8);
        drain(1);

        // 5-bit two-stop frame with bad second stop, then 9-bit frame
        Data_Len = 4'd5; PAR_EN = 1'b0; STOP2 = 1'b1;
        exp_q.push_back({3'b010, 9'h01F});
        send_frame(9'h01F, 5, 0, 1'b0, 1'b1, 1, 1'b0);
        idle(8);
        STOP2 = 1'b0; Data_Len = 4'd9;
        exp_q.push_back({3'b000, 9'h1C3});
        send_frame(9'h1C3, 9, 0, 1'b0, 1'b1, 0, 1'b1);
        idle(8);
        drain(2);

        // Short low pulse is rejected at the start bit
        Prescale = 6'd16; Data_Len = 4'd8;
        idle(4);
        RX_IN = 1'b0;
        idle(3);
        RX_IN = 1'b1;
        t = 0;
        while (!Busy && t < 8) begin @(negedge CLK); t++; end
        check("glitch_busy_rise", 32'(Busy), 32'd1);
        t = 0;
        while (Busy && t < 40) begin @(negedge CLK); t++; end
        check("glitch_busy_fall_in_16", 32'(t <= 16), 32'd1);
        idle(40);
        check("glitch_no_entry", 32'(Data_Valid), 32'd0);

        // Five frames into a 4-deep FIFO with no consumer
        Prescale = 6'd8;
        base = ovr_count;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({3'b000, 9'(i)});
            send_frame(9'(i), 8, 0, 1'b0, 1'b1, 0, 1'b1);
            idle(2);
            if (i == 4) check("no_overrun_before_full", 32'(ovr_count - base), 32'd0);
        end
        idle(10);
        check("overrun_once", 32'(ovr_count - base), 32'd1);
        check("head_held", 32'(P_DATA), 32'h001);
        drain(4);
        idle(2);
        check("empty_after_drain", 32'(Data_Valid), 32'd0);

        // Line held low for the whole frame reads as a break
        exp_q.push_back({3'b110, 9'h000});
        RX_IN = 1'b0;
        idle(100);
        RX_IN = 1'b1;
        idle(10);
        drain(1);

        // Reset in the middle of a frame discards it
        idle(10);
        base = ovr_count;
        RX_IN = 1'b0; idle(8);
        RX_IN = 1'b1; idle(8);
        RX_IN = 1'b0; idle(8);
        check("busy_mid_frame", 32'(Busy), 32'd1);
        RST = 1'b1;
        RX_IN = 1'b1;
        idle(2);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        RST = 1'b0;
        idle(100);
        check("post_rst_valid", 32'(Data_Valid), 32'd0);
        check("post_rst_busy", 32'(Busy), 32'd0);
        check("post_rst_outputs", 32'({Brk_Det, Stp_Err, Par_Err, P_DATA}), 32'd0);
        check("post_rst_overrun", 32'(ovr_count - base), 32'd0);
        check("queue_consumed", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
